// File: rtl/digit_split_if.sv
// Request/result bundle between the BCD digit requesters and the shared divide-by-10 scheduler.
// master = requester side, slave = scheduler side.
interface digit_split_if #(
  parameter int NUM_CH = 6,
  parameter int VAL_W  = 7
);
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*VAL_W-1:0] value;
  logic [NUM_CH-1:0]       ack;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH*4-1:0]     tens;
  logic [NUM_CH*4-1:0]     ones;
  logic [NUM_CH-1:0]       ovf;
  logic                    busy;

  modport master (output req, value, input ack, done, tens, ones, ovf, busy);
  modport slave  (input req, value, output ack, done, tens, ones, ovf, busy);
endinterface

// File: rtl/digit_split_scheduler.sv
// Round-robin shares one subtract-by-10 engine among NUM_CH requesters; done = ack + min(v/10,9) + 2 cycles.
// Requesters hold req until their ack pulse; requests seen while busy simply wait.
module digit_split_scheduler #(
  parameter int NUM_CH = 6,
  parameter int VAL_W  = 7
) (
  input  logic          clk,
  input  logic          rst,
  digit_split_if.slave  bus
);
  localparam int CH_W = $clog2(NUM_CH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SUB   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]          state;
  logic [CH_W-1:0]     last;
  logic [CH_W-1:0]     ch;
  logic [VAL_W-1:0]    work;
  logic [3:0]          cnt;
  logic                ovf_flag;
  logic [NUM_CH-1:0]   ack_r;
  logic [NUM_CH-1:0]   done_r;
  logic [NUM_CH-1:0]   ovf_r;
  logic [NUM_CH*4-1:0] tens_r;
  logic [NUM_CH*4-1:0] ones_r;
  logic                busy_r;
  logic                gnt_vld;
  logic [CH_W-1:0]     gnt_idx;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // Scan starts just after the last granted channel so every requester is served in turn.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!gnt_vld && bus.req[rr_idx(last, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx(last, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last     <= CH_W'(NUM_CH - 1);
      ch       <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      ack_r    <= '0;
      done_r   <= '0;
      ovf_r    <= '0;
      tens_r   <= '0;
      ones_r   <= '0;
      busy_r   <= 1'b0;
    end else begin
      ack_r  <= '0;
      done_r <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            work          <= bus.value[gnt_idx*VAL_W +: VAL_W];
            cnt           <= '0;
            ovf_flag      <= 1'b0;
            ch            <= gnt_idx;
            last          <= gnt_idx;
            ack_r[gnt_idx] <= 1'b1;
            busy_r        <= 1'b1;
            state         <= ST_SUB;
          end
        end
        ST_SUB: begin
          if (work < VAL_W'(10)) begin
            state <= ST_WRITE;
          end else if (cnt == 4'd9) begin
            // Ten or more tens: value is out of two-digit range.
            ovf_flag <= 1'b1;
            state    <= ST_WRITE;
          end else begin
            work <= work - VAL_W'(10);
            cnt  <= cnt + 4'd1;
          end
        end
        ST_WRITE: begin
          tens_r[ch*4 +: 4] <= ovf_flag ? 4'd9 : cnt;
          ones_r[ch*4 +: 4] <= ovf_flag ? 4'd9 : work[3:0];
          ovf_r[ch]         <= ovf_flag;
          done_r[ch]        <= 1'b1;
          busy_r            <= 1'b0;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack  = ack_r;
  assign bus.done = done_r;
  assign bus.tens = tens_r;
  assign bus.ones = ones_r;
  assign bus.ovf  = ovf_r;
  assign bus.busy = busy_r;
endmodule
